// File: rtl/mux_sel_pkg.sv
// Shared types and helpers for the round-robin arbiter that drives the
// 8-way priority select mux.
package mux_sel_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = N_REQ - 1;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } state_t;

    // Requester 7 is the mux's default input, so it is selected by an all-zero vector.
    function automatic logic [SEL_W-1:0] idx_to_select(input logic [IDX_W-1:0] idx);
        logic [SEL_W-1:0] sel;
        sel = '0;
        if (idx != IDX_W'(N_REQ - 1)) begin
            sel = SEL_W'(1) << idx;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mux_sel_rr_pick.sv
// Combinational rotate-and-find-first: the first request at or above
// start_idx (wrapping upward), ignoring bits set in exclude_mask.
module mux_sel_rr_pick
    import mux_sel_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start_idx,
    input  logic [N_REQ-1:0] exclude_mask,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] w_masked;
    logic [IDX_W-1:0] w_cand;

    assign w_masked = req & ~exclude_mask;

    // Walk from the farthest offset down so the nearest hit is written last.
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise the
        // "no request" path would hold its old value and infer a latch.
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_cand = start_idx + IDX_W'(i);
            if (w_masked[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin arbiter with ack handshake and timeout release; every output
// is a register so the downstream mux select never sees a combinational path.
module mux_sel_rr_arbiter
    import mux_sel_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
    output logic [SEL_W-1:0] select,
    output logic             sel_valid,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout_err
);

    localparam int             CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic [SEL_W-1:0] r_select;
    logic             r_sel_valid;
    logic [N_REQ-1:0] r_grant;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_timeout_err;
    logic [IDX_W-1:0] r_last_idx;
    logic [CNT_W-1:0] r_cnt;

    logic             w_granting;
    logic [IDX_W-1:0] w_start_idx;
    logic [N_REQ-1:0] w_exclude;
    logic             w_found;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_release;

    // During a grant the search starts past the current grantee and skips it,
    // which puts a still-requesting grantee behind everyone else.
    assign w_granting  = (r_state == GRANT);
    assign w_start_idx = (w_granting ? r_grant_idx : r_last_idx) + IDX_W'(1);
    assign w_exclude   = w_granting ? r_grant : '0;
    assign w_release   = ack || (r_cnt == CNT_LAST);

    mux_sel_rr_pick u_pick (
        .req          (req),
        .start_idx    (w_start_idx),
        .exclude_mask (w_exclude),
        .found        (w_found),
        .idx          (w_pick_idx)
    );

    // NOTE: all state here uses non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_select      <= '0;
            r_sel_valid   <= 1'b0;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_timeout_err <= 1'b0;
            r_last_idx    <= IDX_W'(N_REQ - 1);
            r_cnt         <= '0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state     <= GRANT;
                        r_select    <= idx_to_select(w_pick_idx);
                        r_sel_valid <= 1'b1;
                        r_grant     <= N_REQ'(1) << w_pick_idx;
                        r_grant_idx <= w_pick_idx;
                        r_cnt       <= '0;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        // An ack in the expiry cycle wins, so no error pulse.
                        r_timeout_err <= !ack;
                        r_last_idx    <= r_grant_idx;
                        r_cnt         <= '0;
                        if (w_found) begin
                            r_select    <= idx_to_select(w_pick_idx);
                            r_grant     <= N_REQ'(1) << w_pick_idx;
                            r_grant_idx <= w_pick_idx;
                        end else begin
                            r_state     <= IDLE;
                            r_select    <= '0;
                            r_sel_valid <= 1'b0;
                            r_grant     <= '0;
                            r_grant_idx <= '0;
                        end
                    end else begin
                        // Release fires at CNT_LAST, so the counter never wraps.
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign select      = r_select;
    assign sel_valid   = r_sel_valid;
    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// Directed bench for mux_sel_rr_arbiter: a behavioural round-robin model is
// compared every cycle, with hand-computed checkpoints along the way.
module tb_mux_sel_rr_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk;
    logic       reset_n;
    logic [7:0] req;
    logic       ack;
    logic [6:0] select;
    logic       sel_valid;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       timeout_err;

    int n_vec = 0;
    int n_err = 0;

    mux_sel_rr_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .ack         (ack),
        .select      (select),
        .sel_valid   (sel_valid),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outputs packed as {grant, select, grant_idx, sel_valid, timeout_err}.
    function automatic logic [19:0] outs_now();
        return {grant, select, grant_idx, sel_valid, timeout_err};
    endfunction

    task automatic chk_out(input string name, input logic [7:0] g, input logic [6:0] s,
                           input logic [2:0] i, input logic v, input logic t);
        check(name, 32'(outs_now()), 32'({g, s, i, v, t}));
    endtask

    // Behavioural model: who holds the grant, for how many cycles it has been
    // visible, and who was served last.
    bit m_valid;
    int m_idx;
    int m_last;
    int m_age;
    bit m_terr;

    function automatic int rr_pick(input logic [7:0] r, input int start, input int skip);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (start + k) % 8;
            if (r[j] && j != skip) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_last  <= 7;
            m_age   <= 0;
            m_terr  <= 1'b0;
        end else begin
            m_terr <= 1'b0;
            if (!m_valid) begin
                if (rr_pick(req, m_last + 1, -1) >= 0) begin
                    m_valid <= 1'b1;
                    m_idx   <= rr_pick(req, m_last + 1, -1);
                    m_age   <= 1;
                end
            end else if (ack || m_age == TIMEOUT) begin
                m_terr <= !ack;
                m_last <= m_idx;
                if (rr_pick(req, m_idx + 1, m_idx) >= 0) begin
                    m_idx <= rr_pick(req, m_idx + 1, m_idx);
                    m_age <= 1;
                end else begin
                    m_valid <= 1'b0;
                    m_idx   <= 0;
                    m_age   <= 0;
                end
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    function automatic logic [19:0] model_outs();
        logic [7:0] g;
        logic [6:0] s;
        g = m_valid ? 8'(1 << m_idx) : 8'h00;
        s = (m_valid && m_idx < 7) ? 7'(1 << m_idx) : 7'h00;
        return {g, s, 3'(m_idx), m_valid, m_terr};
    endfunction

    always @(posedge clk) begin
        #1;
        check("model", 32'(outs_now()), 32'(model_outs()));
    end

    task automatic cyc(input logic [7:0] r, input logic a);
        @(negedge clk);
        req = r;
        ack = a;
        @(posedge clk);
        #2;
    endtask

    logic [2:0] rr_seq [8];

    initial begin
        rr_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        reset_n = 1'b0;
        req     = 8'h00;
        ack     = 1'b0;
        repeat (2) @(negedge clk);
        chk_out("reset_state", 8'h00, 7'h00, 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Everyone requesting, ack every cycle: 0,1,...,7,0 with no gaps.
        cyc(8'hFF, 1'b0);
        chk_out("all_first", 8'h01, 7'h01, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(8'hFF, 1'b1);
            check("all_seq_idx", 32'(grant_idx), 32'(rr_seq[i]));
            check("all_seq_valid", 32'(sel_valid), 32'd1);
        end
        cyc(8'h00, 1'b1);
        chk_out("all_idle", 8'h00, 7'h00, 3'd0, 1'b0, 1'b0);

        // Single request.
        cyc(8'h04, 1'b0);
        chk_out("single_grant", 8'h04, 7'h04, 3'd2, 1'b1, 1'b0);
        cyc(8'h00, 1'b1);
        chk_out("single_idle", 8'h00, 7'h00, 3'd0, 1'b0, 1'b0);
        cyc(8'h00, 1'b1);
        chk_out("ack_while_idle", 8'h00, 7'h00, 3'd0, 1'b0, 1'b0);

        // Requester 7 is routed by the all-zero select.
        cyc(8'h80, 1'b0);
        chk_out("req7_grant", 8'h80, 7'h00, 3'd7, 1'b1, 1'b0);
        cyc(8'h00, 1'b1);

        // Timeout: grant 0 held 16 cycles, then forced to 3 with an error pulse.
        cyc(8'h09, 1'b0);
        chk_out("to_grant0", 8'h01, 7'h01, 3'd0, 1'b1, 1'b0);
        for (int i = 1; i < TIMEOUT; i++) cyc(8'h09, 1'b0);
        chk_out("to_hold_last", 8'h01, 7'h01, 3'd0, 1'b1, 1'b0);
        cyc(8'h09, 1'b0);
        chk_out("to_release", 8'h08, 7'h08, 3'd3, 1'b1, 1'b1);
        cyc(8'h09, 1'b0);
        chk_out("to_pulse_end", 8'h08, 7'h08, 3'd3, 1'b1, 1'b0);
        cyc(8'h01, 1'b1);
        chk_out("to_ack3", 8'h01, 7'h01, 3'd0, 1'b1, 1'b0);

        // Ack arriving in the expiry cycle is a normal handoff.
        for (int i = 1; i < TIMEOUT; i++) cyc(8'h09, 1'b0);
        cyc(8'h09, 1'b1);
        chk_out("ack_at_expiry", 8'h08, 7'h08, 3'd3, 1'b1, 1'b0);
        cyc(8'h00, 1'b1);

        // Reset in the middle of a grant to 5.
        cyc(8'h20, 1'b0);
        chk_out("pre_reset_grant5", 8'h20, 7'h20, 3'd5, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("async_reset", 8'h00, 7'h00, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        req     = 8'h21;
        ack     = 1'b0;
        @(posedge clk);
        #2;
        chk_out("post_reset_grant0", 8'h01, 7'h01, 3'd0, 1'b1, 1'b0);
        cyc(8'h20, 1'b1);
        chk_out("post_reset_next5", 8'h20, 7'h20, 3'd5, 1'b1, 1'b0);
        cyc(8'h00, 1'b1);
        chk_out("final_idle", 8'h00, 7'h00, 3'd0, 1'b0, 1'b0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_sel_rr_arbiter.md
# mux_sel_rr_arbiter

Round-robin arbiter that sits directly upstream of the 8-way priority select mux and drives its 7-bit `select` vector. It takes eight request lines and grants one requester at a time. The grant is encoded so the downstream priority chain routes exactly that requester's input: one-hot on `select[6:0]`, or all-zero for requester 7, which is the mux's default input. The grant is held until the consumer acknowledges it, and a grant that is never acknowledged is released by a timeout.

## Interface
- `N_REQ`, 8, number of requesters; fixed at 8 to match the mux.
- `SEL_W`, 7, select width; equals `N_REQ`-1.
- `TIMEOUT`, 16, cycles a grant may stay un-acked before forced release; legal range 2..255.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  request per requester; level, held until granted.
- `ack`  in  1  consumer has taken the granted input this cycle; ignored unless `sel_valid`=1.
- `select`  out  7  priority-mux select; one-hot for grantee 0..6, 0 for grantee 7 or no grant.
- `sel_valid`  out  1  a grant is active; the mux output is meaningful.
- `grant`  out  8  one-hot grant; 0 when idle.
- `grant_idx`  out  3  index of the current grantee.
- `timeout_err`  out  1  one-cycle pulse on forced release.

## Operation
- Reset values: state IDLE, `select`=0, `sel_valid`=0, `grant`=0, `grant_idx`=0, `timeout_err`=0, `last_idx`=7, wait counter=0.
- Round-robin pick: search `req` starting at (`last_idx`+1) mod 8 and wrapping upward. The first set bit wins.
- IDLE → GRANT when `req`≠0. The picked index is registered into `grant`, `grant_idx` and `select`, and `sel_valid` is set.
- GRANT with `ack`=1:
  - `last_idx` ← `grant_idx` and the counter clears.
  - If another request is pending, excluding the current grantee's bit, a new pick is registered with no idle bubble (GRANT → GRANT).
  - Otherwise the block returns to IDLE and all grant outputs clear.
  - A current grantee whose `req` is still high competes again only after all others (lowest priority).
- GRANT with `ack`=0: the counter increments.
  - When the counter equals `TIMEOUT`-1 and `ack` is still 0, the grant is forcibly released.
  - On release: `timeout_err` pulses, `last_idx` ← `grant_idx`, and the next pick follows the same rule as an ack.
- `ack` together with timeout expiry in the same cycle is treated as an ack; no `timeout_err`.
- `req` of the grantee dropping mid-grant has no effect; the grant persists until ack or timeout.
- `ack` while IDLE is ignored.
- `select` encoding: grantee k<7 gives `select`=1<<k; grantee 7 gives `select`=0 with `sel_valid`=1.
- Counter width is $clog2(`TIMEOUT`). The counter saturates and never wraps.

## Timing
- Latency from request to grant: `req` sampled at edge N, grant outputs valid after edge N+1 (1 cycle).
- Handoff: `ack` at edge M gives the new grant visible after M+1, so back-to-back grants run at one per cycle.
- All outputs are registered, with no combinational path from `req` or `ack` to any output.
- Asynchronous reset asserted mid-grant: all outputs clear immediately, without waiting for a clock edge. After deassertion, arbitration restarts from requester 0.
- Timeout: a grant issued at edge G with no ack is released at edge G+`TIMEOUT`. `timeout_err` is high for the following cycle.

## Structure
- Package `mux_sel_pkg` holds:
  - `N_REQ`, `SEL_W` and `IDX_W`=3;
  - the state enum {IDLE, GRANT};
  - function `idx_to_select(idx)` that returns the 7-bit select.
- Sub-module `mux_sel_rr_pick`: combinational rotate-and-find-first.
  - Inputs: `req`, `start_idx`, `exclude_mask`.
  - Outputs: `found`, `idx`.
- Top level holds the FSM, the registers and the wait counter.

## Test plan
- Single request: `req`=8'h04 → after 1 cycle `grant`=8'h04, `select`=7'h04, `grant_idx`=2; `ack` → IDLE, all outputs 0.
- All requesting: `req`=8'hFF held, `ack` every cycle → `grant_idx` sequence 0,1,2,…,7,0 with no gap cycles.
- Requester 7 only: `req`=8'h80 → `sel_valid`=1, `select`=7'h00, `grant`=8'h80.
- Timeout: `TIMEOUT`=16, `req`=8'h09, never ack → grant to 0 for 16 cycles, then `timeout_err` pulse and grant moves to 3.
- Ack coincident with expiry: `ack`=1 on cycle 16 → no `timeout_err`, normal handoff.
- Reset mid-grant: `reset_n` low while grant to 5 → outputs 0 immediately; after release with `req`=8'h21 the grant goes to 0, not 5.
